// File: rtl/mem_copy_ctrl.sv
// mem_copy_ctrl: byte/word memory-to-memory copy engine.
// Each beat is one read then one write; word beats are used while 4+ bytes remain.
`default_nettype none

module mem_copy_ctrl #(
  parameter int WIDTH = 7,
  parameter int AW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    src_base,
  input  logic [AW-1:0]    dst_base,
  input  logic [WIDTH-1:0] len,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_word,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    src_q, dst_q;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH:0]   off_q;
  logic [31:0]      buf_q;
  logic             word;
  logic [WIDTH:0]   off_inc;

  // Offset never exceeds len, so offset+4 cannot wrap in WIDTH+1 bits.
  assign word    = (off_q + (WIDTH+1)'(4)) <= {1'b0, len_q};
  assign off_inc = off_q + (word ? (WIDTH+1)'(4) : (WIDTH+1)'(1));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      off_q <= '0;
      buf_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          src_q <= src_base;
          dst_q <= dst_base;
          len_q <= len;
          off_q <= '0;
        end
        RD: if (mem_ack) buf_q <= mem_rdata;
        WR: if (mem_ack) off_q <= off_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_word  = 1'b0;
    mem_wdata = '0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (len == '0) ? FIN : RD;
      RD: begin
        mem_req  = 1'b1;
        mem_addr = src_q + AW'(off_q);
        mem_word = word;
        if (mem_ack) state_nx = WR;
      end
      WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_q + AW'(off_q);
        mem_word  = word;
        mem_wdata = word ? buf_q : {24'b0, buf_q[7:0]};
        if (mem_ack) state_nx = (off_inc == {1'b0, len_q}) ? FIN : RD;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_ctrl.sv
// Testbench for mem_copy_ctrl: a memory responder with random ack latency,
// checked against a beat list computed directly from the copy rules.
`default_nettype none

module tb_mem_copy_ctrl;
  localparam int WIDTH = 7;
  localparam int AW    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    src_base, dst_base;
  logic [WIDTH-1:0] len;
  logic             mem_req, mem_we, mem_word, busy, done, mem_ack;
  logic [AW-1:0]    mem_addr;
  logic [31:0]      mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_copy_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .len(len), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_word(mem_word), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .done(done)
  );

  // Runs one copy with a responder acking after dlo..dhi wait cycles.
  // junk: pulse start with other inputs mid-copy. abort: reset during 2nd write.
  task automatic run_copy(input string name, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input int l, input int dlo, input int dhi,
                          input bit junk, input bit abort, output int done_cyc);
    int beat_off[$];
    bit beat_word[$];
    int off, ai, b, waited, cur_dly, cyc, exp_done;
    bit finished, w, exp_we, exp_word;
    logic [31:0] rd_val, exp_data;
    logic [AW-1:0] exp_addr;
    off = 0;
    while (off < l) begin
      w = (off + 4 <= l);
      beat_off.push_back(off);
      beat_word.push_back(w);
      off += w ? 4 : 1;
    end
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1; src_base = s; dst_base = d; len = WIDTH'(l); mem_ack = 1'b0;
    @(negedge clk);
    src_base = $urandom; dst_base = $urandom; len = WIDTH'($urandom);
    ai = 0; waited = 0; cur_dly = $urandom_range(dhi, dlo);
    exp_done = 1; finished = 0; cyc = 1; rd_val = '0;
    while (!finished) begin
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      start = (junk && cyc == 2) ? 1'b1 : 1'b0;
      if (!done) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++; $display("FAIL %s busy cyc %0d: got %b exp 1", name, cyc, busy);
        end
      end
      if (mem_req === 1'b1) begin
        if (ai >= 2 * beat_off.size()) begin
          n_cmp++; n_err++;
          $display("FAIL %s extra_req cyc %0d: got req=1 exp req=0", name, cyc);
          finished = 1;
        end else begin
          exp_we   = ai[0];
          b        = ai / 2;
          exp_addr = (exp_we ? d : s) + 32'(beat_off[b]);
          exp_word = beat_word[b];
          exp_data = exp_word ? rd_val : {24'b0, rd_val[7:0]};
          n_cmp++;
          if (mem_we !== exp_we || mem_addr !== exp_addr || mem_word !== exp_word) begin
            n_err++;
            $display("FAIL %s access %0d: got we=%b addr=%h word=%b exp we=%b addr=%h word=%b",
                     name, ai, mem_we, mem_addr, mem_word, exp_we, exp_addr, exp_word);
          end
          if (exp_we) begin
            n_cmp++;
            if (mem_wdata !== exp_data) begin
              n_err++; $display("FAIL %s wdata %0d: got %h exp %h", name, ai, mem_wdata, exp_data);
            end
          end
          if (abort && exp_we && b == 1) begin
            rst = 1'b1;
            #1;
            n_cmp++;
            if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
              n_err++;
              $display("FAIL %s async_rst: got req=%b busy=%b done=%b exp 0 0 0", name, mem_req, busy, done);
            end
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
              @(negedge clk);
              n_cmp++;
              if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL %s post_rst: got done=%b busy=%b req=%b exp 0 0 0", name, done, busy, mem_req);
              end
            end
            return;
          end
          if (waited == cur_dly) begin
            mem_ack = 1'b1;
            if (!exp_we) rd_val = mem_rdata;
            exp_done += cur_dly + 1;
            ai++;
            waited = 0;
            cur_dly = $urandom_range(dhi, dlo);
          end else begin
            waited++;
          end
        end
      end else if (done === 1'b1) begin
        finished = 1;
        done_cyc = cyc;
        n_cmp++;
        if (cyc != exp_done || ai != 2 * beat_off.size() || busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s done: got cyc=%0d accesses=%0d busy=%b exp cyc=%0d accesses=%0d busy=1",
                   name, cyc, ai, busy, exp_done, 2 * beat_off.size());
        end
      end else begin
        mem_ack = 1'($urandom);
        n_cmp++; n_err++;
        $display("FAIL %s stall cyc %0d: got req=0 done=0 exp activity", name, cyc);
      end
      if (!finished && cyc > 2000) begin
        n_cmp++; n_err++;
        $display("FAIL %s timeout: got no done exp done by cyc %0d", name, exp_done);
        finished = 1;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    mem_ack = 1'($urandom);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== '0 ||
        mem_we !== 1'b0 || mem_word !== 1'b0 || mem_wdata !== '0) begin
      n_err++;
      $display("FAIL %s idle_after: got done=%b busy=%b req=%b addr=%h exp all 0",
               name, done, busy, mem_req, mem_addr);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_word !== 1'b0 ||
        mem_wdata !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got req=%b we=%b addr=%h word=%b wdata=%h busy=%b done=%b exp all 0",
               mem_req, mem_we, mem_addr, mem_word, mem_wdata, busy, done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL idle_ack: got busy=%b req=%b exp 0 0", busy, mem_req);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_word_copy();
    int dc;
    run_copy("word8", 32'h100, 32'h200, 8, 0, 0, 0, 0, dc);
    n_cmp++;
    if (dc != 5) begin
      n_err++; $display("FAIL word8_latency: got %0d exp 5", dc);
    end
  endtask

  task automatic test_mixed();
    int dc;
    run_copy("mixed6", 32'h100, 32'h200, 6, 0, 0, 0, 0, dc);
    run_copy("mixed7_slow", 32'h100, 32'h200, 7, 1, 2, 0, 0, dc);
  endtask

  task automatic test_zero_len();
    int dc;
    run_copy("len0", 32'h100, 32'h200, 0, 0, 0, 0, 0, dc);
    n_cmp++;
    if (dc != 1) begin
      n_err++; $display("FAIL len0_latency: got %0d exp 1", dc);
    end
  endtask

  task automatic test_ack_delay();
    int dc;
    run_copy("delay3", 32'h100, 32'h200, 4, 3, 3, 0, 0, dc);
    n_cmp++;
    if (dc != 9) begin
      n_err++; $display("FAIL delay3_latency: got %0d exp 9", dc);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    run_copy("abort", 32'h100, 32'h200, 8, 0, 1, 0, 1, dc);
    run_copy("after_abort", 32'h300, 32'h400, 4, 0, 0, 0, 0, dc);
    n_cmp++;
    if (dc != 3) begin
      n_err++; $display("FAIL after_abort_latency: got %0d exp 3", dc);
    end
  endtask

  task automatic test_start_while_busy();
    int dc;
    run_copy("busy_start", 32'h1000, 32'h2000, 9, 0, 1, 1, 0, dc);
  endtask

  task automatic test_random();
    int dc;
    logic [AW-1:0] s, d;
    for (int i = 0; i < 20; i++) begin
      s = (i % 5 == 0) ? 32'hFFFF_FFFC - 32'($urandom_range(3, 0)) : $urandom;
      d = (i % 7 == 0) ? 32'hFFFF_FFFE : $urandom;
      run_copy("random", s, d, $urandom_range(127, 0), 0, 2, 0, 0, dc);
    end
    run_copy("max_len", $urandom, $urandom, 127, 0, 1, 0, 0, dc);
  endtask

  initial begin
    test_reset();
    test_word_copy();
    test_mixed();
    test_zero_len();
    test_ack_delay();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_copy_ctrl.md
MEM_COPY_CTRL -- requirements
Module: mem_copy_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 7: bit width of the transfer length in bytes.
REQ-002 SHALL have parameter AW, default 32: memory address width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request a copy, sampled only in IDLE.
REQ-006 SHALL have port src_base  input  AW  source byte address, latched on accepted start.
REQ-007 SHALL have port dst_base  input  AW  destination byte address, latched on accepted start.
REQ-008 SHALL have port len  input  WIDTH  byte count, latched on accepted start.
REQ-009 SHALL have port mem_req  output  1  memory access request, held high until mem_ack.
REQ-010 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-011 SHALL have port mem_addr  output  AW  byte address of the current access.
REQ-012 SHALL have port mem_word  output  1  1 = 32-bit word access, 0 = single-byte access.
REQ-013 SHALL have port mem_wdata  output  32  write data; bytes use bits [7:0], upper bits 0.
REQ-014 SHALL have port mem_rdata  input  32  read data, valid in the cycle mem_ack is high.
REQ-015 SHALL have port mem_ack  input  1  access complete; sampled only while mem_req is high.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at the end of each copy.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, FIN.
REQ-019 IDLE: on start=1 SHALL latch src_base, dst_base and len, and clear the offset to 0.
REQ-020 IDLE: on start=1 SHALL move to RD if len!=0, else to FIN.
REQ-021 RD: mem_req=1, mem_we=0, mem_addr=src+offset.
REQ-022 RD: on mem_ack SHALL capture mem_rdata into the data buffer and move to WR.
REQ-023 WR: mem_req=1, mem_we=1, mem_addr=dst+offset, mem_wdata=buffer (bytes: {24'b0,buffer[7:0]}).
REQ-024 WR: on mem_ack SHALL advance the offset by 4 if word, else by 1.
REQ-025 WR: on mem_ack SHALL move to FIN if the new offset equals len, else to RD.
REQ-026 FIN: done=1 for exactly one cycle, then SHALL move to IDLE.
REQ-027 mem_word SHALL be 1 iff offset+4 <= len, computed in WIDTH+1 bits (no wrap); the value is identical for the RD and WR of a beat.
REQ-028 Address addition SHALL wrap modulo 2^AW.
REQ-029 The offset register SHALL be WIDTH+1 bits and SHALL never exceed len.
REQ-030 mem_addr, mem_we, mem_word and mem_wdata SHALL stay stable while mem_req=1 and mem_ack=0.
REQ-031 mem_ack in the first cycle of a request SHALL be honoured; minimum 2 cycles per beat.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.
REQ-033 start while busy=1 SHALL be ignored, with no relatch of inputs.
REQ-034 In IDLE and FIN, mem_req, mem_we, mem_word, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-035 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE, offset 0, buffer 0, all latched inputs 0, and all outputs 0.
REQ-036 rst asserted mid-transfer SHALL abandon the copy with no done pulse; a start after rst release SHALL begin a fresh copy.

Verification
REQ-037 len=8, src=0x100, dst=0x200, mem_ack every request cycle -> RD 0x100 word, WR 0x200 word, RD 0x104 word, WR 0x204 word; done high in the 5th cycle after the start edge.
REQ-038 len=6, src=0x100, dst=0x200 -> beats at offsets 0 (word), 4 (byte), 5 (byte); WR at 0x205 carries {24'b0, rdata[7:0]}.
REQ-039 len=0 with start -> busy high 1 cycle, done pulse, mem_req never asserted.
REQ-040 mem_ack delayed 3 cycles in RD -> mem_req and mem_addr held constant for 4 cycles, then WR.
REQ-041 rst pulse during WR of beat 2 -> mem_req drops 0 immediately, no done; a new start with len=4 completes normally.
REQ-042 start pulsed with new src/len while busy -> ignored; the original copy completes with the original addresses.
